// File: rtl/bluetooth_cmd_serializer.sv
// ---------------------------------------------------------------------------
// bluetooth_cmd_serializer
//
// Builds a complete Bluetooth AT command and streams it one byte at a time
// over a valid/ready byte interface into the UART transmitter. A command is
// a fixed ASCII prefix, an optional variable-length payload (TX command
// only) and an optional CR/LF terminator.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous, active-high reset
//   start          - request to send a command (sampled only in IDLE)
//   command_select - 1 = TX-with-payload, 2 = RX poll, 3 = ping
//   payload_data   - payload bytes, byte 0 in bits [7:0], sent first
//   payload_len    - number of payload bytes to send (command 1 only)
//   tx_byte        - byte currently offered to the UART
//   tx_valid       - tx_byte is valid
//   tx_ready       - UART accepts tx_byte this cycle
//   busy           - command in progress, start is ignored
//   done           - one-cycle pulse after the last byte is accepted
//   error          - one-cycle pulse when an illegal command is rejected
// ---------------------------------------------------------------------------
module bluetooth_cmd_serializer #(
   parameter int PAYLOAD_BYTES = 16,
   parameter int LEN_W         = 8,
   parameter bit APPEND_CRLF   = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [3:0]                 command_select,
   input  logic [8*PAYLOAD_BYTES-1:0] payload_data,
   input  logic [LEN_W-1:0]           payload_len,
   output logic [7:0]                 tx_byte,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   // Longest possible command: 13 prefix bytes, full payload, CR/LF.
   localparam int MAX_BYTES = 13 + PAYLOAD_BYTES + 2;
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAYLOAD_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFIX,
      S_PAYLOAD,
      S_TERM,
      S_DONE
   } state_t;

   state_t                     state;
   state_t                     state_next;
   logic [3:0]                 cmd_q;
   logic [8*PAYLOAD_BYTES-1:0] payload_q;
   logic [CNT_W-1:0]           len_q;
   logic [CNT_W-1:0]           idx;
   logic                       error_q;
   logic                       fire;
   logic                       cmd_legal;
   logic                       accept;
   logic [LEN_W-1:0]           len_clamped;
   int                         pos;
   int                         prefix_last_pos;
   logic [7:0]                 prefix_byte;
   logic [7:0]                 payload_byte;

   assign fire        = tx_valid & tx_ready;
   assign cmd_legal   = (command_select == 4'd1) || (command_select == 4'd2) ||
                        (command_select == 4'd3);
   assign accept      = (state == S_IDLE) && start && cmd_legal;
   assign len_clamped = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
   assign pos         = int'(idx);

   assign tx_valid = (state == S_PREFIX) || (state == S_PAYLOAD) || (state == S_TERM);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign error    = error_q;

   // State register, command capture and the per-state byte counter.
   // The counter restarts at zero on every state change so each phase
   // indexes its own bytes from 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         payload_q <= '0;
         len_q     <= '0;
         idx       <= '0;
         error_q   <= 1'b0;
      end else begin
         state   <= state_next;
         error_q <= (state == S_IDLE) && start && !cmd_legal;
         if (accept) begin
            cmd_q     <= command_select;
            payload_q <= payload_data;
            len_q     <= CNT_W'(len_clamped);
         end
         if (state_next != state) begin
            idx <= '0;
         end else if (fire) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Index of the final prefix byte for the captured command.
   always_comb begin
      prefix_last_pos = 1;
      case (cmd_q)
         4'd1:    prefix_last_pos = 12;
         4'd2:    prefix_last_pos = 11;
         default: prefix_last_pos = 1;
      endcase
   end

   // Next-state logic. A phase ends only when its last byte is transferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = S_PREFIX;
            end
         end
         S_PREFIX: begin
            if (fire && (pos == prefix_last_pos)) begin
               if ((cmd_q == 4'd1) && (len_q != '0)) begin
                  state_next = S_PAYLOAD;
               end else if (APPEND_CRLF) begin
                  state_next = S_TERM;
               end else begin
                  state_next = S_DONE;
               end
            end
         end
         S_PAYLOAD: begin
            if (fire && (pos == int'(len_q) - 1)) begin
               state_next = APPEND_CRLF ? S_TERM : S_DONE;
            end
         end
         S_TERM: begin
            if (fire && (pos == 1)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Prefix ROM. All three commands share "AT+BLEUART..." up to index 9,
   // so the ping command ("AT") is simply the first two entries.
   always_comb begin
      prefix_byte = 8'h00;
      case (pos)
         0:  prefix_byte = "A";
         1:  prefix_byte = "T";
         2:  prefix_byte = "+";
         3:  prefix_byte = "B";
         4:  prefix_byte = "L";
         5:  prefix_byte = "E";
         6:  prefix_byte = "U";
         7:  prefix_byte = "A";
         8:  prefix_byte = "R";
         9:  prefix_byte = "T";
         10: prefix_byte = (cmd_q == 4'd1) ? "T" : "R";
         11: prefix_byte = "X";
         12: prefix_byte = "=";
         default: prefix_byte = 8'h00;
      endcase
   end

   // Select the captured payload byte addressed by the counter.
   always_comb begin
      payload_byte = 8'h00;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         if (pos == i) begin
            payload_byte = payload_q[i*8 +: 8];
         end
      end
   end

   // Output byte mux; zero whenever nothing is offered.
   always_comb begin
      tx_byte = 8'h00;
      case (state)
         S_PREFIX:  tx_byte = prefix_byte;
         S_PAYLOAD: tx_byte = payload_byte;
         S_TERM:    tx_byte = (pos == 0) ? 8'h0D : 8'h0A;
         default:   tx_byte = 8'h00;
      endcase
   end

endmodule

// File: doc/bluetooth_cmd_serializer.md
Name: bluetooth_cmd_serializer

Overview:
Parametrised successor to the team's fixed-width Bluetooth AT-command encoder. It builds a complete AT command (prefix, variable-length payload, optional CR/LF terminator) and streams it one byte per transfer over a valid/ready byte interface into the UART transmitter. It sits between the sensor/control logic and the UART TX block that drives the BLE module.

Parameters:
PAYLOAD_BYTES, 16, maximum payload bytes per command (1..255)
LEN_W, 8, width of payload_len; must satisfy 2**LEN_W > PAYLOAD_BYTES
APPEND_CRLF, 1, 1 = send 0x0D 0x0A after each command; 0 = no terminator

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to send a command; sampled only in IDLE
command_select  input  4  1 = TX-with-payload, 2 = RX poll, 3 = ping
payload_data  input  8*PAYLOAD_BYTES  payload; byte 0 = bits [7:0], sent first
payload_len  input  LEN_W  number of payload bytes to send (command 1 only)
tx_byte  output  8  current byte offered to the UART
tx_valid  output  1  tx_byte is valid
tx_ready  input  1  UART accepts tx_byte this cycle
busy  output  1  command in progress (start ignored)
done  output  1  one-cycle pulse: last byte accepted
error  output  1  one-cycle pulse: illegal command_select rejected

Behaviour:
- Reset (synchronous): state IDLE; tx_byte=0x00, tx_valid=0, busy=0, done=0, error=0; internal captures cleared. A reset mid-command aborts it: no further bytes, no done pulse.
- Command strings (ASCII, in send order):
  - 1: "AT+BLEUARTTX=" (13 bytes), then payload bytes 0..N-1, then terminator.
  - 2: "AT+BLEUARTRX" (12 bytes), then terminator.
  - 3: "AT" (2 bytes), then terminator.
  - Terminator: 0x0D, 0x0A when APPEND_CRLF=1, otherwise none.
- On start in IDLE: command_select, payload_data and payload_len are captured into registers; later changes to these inputs have no effect on the command in flight.
- N = min(payload_len, PAYLOAD_BYTES). payload_len=0 sends the prefix and terminator only, with no payload.
- Illegal command_select (0 or 4..15) with start in IDLE: error pulses the next cycle; no bytes are sent; busy stays 0; state stays IDLE.
- States:
  - IDLE: start with a legal command -> PREFIX.
  - PREFIX: after the last prefix byte is accepted -> PAYLOAD if command 1 and N>0; else TERM if APPEND_CRLF; else DONE.
  - PAYLOAD: after byte N-1 is accepted -> TERM if APPEND_CRLF, else DONE.
  - TERM: after 0x0A is accepted -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Timing:
  - busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
  - tx_valid rises the cycle after start is accepted.
  - Done pulses the cycle after the final transfer.
  - start may be re-accepted in the cycle after DONE.
- Handshake:
  - A transfer occurs on a cycle where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_byte holds stable and tx_valid stays high (no retraction).
  - After a transfer, the next byte is presented in the following cycle with tx_valid held high. Back-to-back throughput is 1 byte/cycle with tx_ready tied high.
  - tx_valid=0 in IDLE and DONE.
- Byte/index counter width is sized for 13+PAYLOAD_BYTES+2. There is no wrap-around; the counter resets on each state entry.
- start asserted while busy is ignored; it is not queued.

Test Plan:
1. Command 1, payload_len=4, payload_data[31:0]=0x34333231, tx_ready=1, APPEND_CRLF=1 -> bytes "AT+BLEUARTTX=1234\r\n" (19 bytes) on 19 consecutive cycles; done pulses once on cycle 21 after start; busy high for 20 cycles.
2. Command 2 with tx_ready toggling 1,0,0,1,... -> "AT+BLEUARTRX\r\n" (14 bytes); tx_byte stable and tx_valid high during every stall; no byte duplicated or dropped.
3. command_select=7 with start -> error pulse one cycle; tx_valid stays 0; busy 0; a following command 3 produces "AT\r\n".
4. Command 1 with payload_len=20, PAYLOAD_BYTES=16 -> clamped to 16 payload bytes (31 total); payload_len=0 -> "AT+BLEUARTTX=\r\n" (15 bytes).
5. Reset asserted after the 5th byte of command 1 -> next cycle tx_valid=0, busy=0; no done pulse; a new start sends the full command from 'A'.
6. start held high and payload_data changed mid-command -> output uses the captured payload; the second command starts only after DONE; with APPEND_CRLF=0, command 3 yields exactly "AT".
